// File: rtl/sensor_decimator.sv
// Block-averaging decimator: sums 2^LOG2_N samples per frame, rounds half-up to
// BW_OUT bits and hands the result over through a one-entry valid/ready register.
module sensor_decimator #(
    parameter int BW_IN  = 5,
    parameter int BW_OUT = 3,
    parameter int LOG2_N = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              data_is_signed,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BW_IN-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BW_OUT-1:0] out_data,
    output logic              frame_busy
);

    localparam int ACC_W = BW_IN + LOG2_N;
    localparam int SHIFT = ACC_W - BW_OUT;

    typedef enum logic {S_EMPTY, S_FULL} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ACC_W-1:0]    r_acc;
    logic [LOG2_N-1:0]   r_cnt;
    logic                r_mode;
    logic [BW_OUT-1:0]   r_out;

    logic                w_mode;
    logic                w_last;
    logic                w_accept;
    logic                w_frame_done;
    logic                w_pop;
    logic [ACC_W-1:0]    w_ext;
    logic [ACC_W-1:0]    w_sum;
    logic [BW_OUT-1:0]   w_round;

    // The first sample of a frame is extended with the live mode input, later ones with the latch.
    assign w_mode  = (r_cnt == '0) ? data_is_signed : r_mode;
    assign w_ext   = w_mode ? {{LOG2_N{in_data[BW_IN-1]}}, in_data}
                            : {{LOG2_N{1'b0}}, in_data};
    assign w_sum   = r_acc + w_ext;
    assign w_round = w_sum[ACC_W-1:SHIFT] + BW_OUT'(w_sum[SHIFT-1]);

    assign w_last       = (r_cnt == '1);
    assign w_pop        = out_valid & out_ready;
    assign in_ready     = !clr && !(w_last && out_valid && !out_ready);
    assign w_accept     = in_valid & in_ready;
    assign w_frame_done = w_accept & w_last;

    assign out_valid  = (r_state == S_FULL);
    assign out_data   = r_out;
    assign frame_busy = (r_cnt != '0);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_EMPTY: if (w_frame_done) w_state_nxt = S_FULL;
            S_FULL:  if (w_pop && !w_frame_done) w_state_nxt = S_EMPTY;
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_EMPTY;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc  <= '0;
            r_cnt  <= '0;
            r_mode <= 1'b0;
            r_out  <= '0;
        end else begin
            if (clr) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else if (w_accept) begin
                if (w_last) begin
                    r_acc <= '0;
                    r_cnt <= '0;
                end else begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + LOG2_N'(1);
                end
            end
            if (w_accept && (r_cnt == '0)) r_mode <= data_is_signed;
            if (w_frame_done)              r_out  <= w_round;
        end
    end

endmodule

// File: tb/tb_sensor_decimator.sv
// Scoreboard bench for sensor_decimator: a frame model pushes expected results on
// accepted samples; a negedge monitor pops and compares on every output handshake.
module tb_sensor_decimator;

    localparam int BW_IN  = 5;
    localparam int BW_OUT = 3;
    localparam int LOG2_N = 2;
    localparam int N      = 1 << LOG2_N;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              data_is_signed = 1'b0;
    logic              clr = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [BW_IN-1:0]  in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [BW_OUT-1:0] out_data;
    logic              frame_busy;

    int n_checks = 0;
    int n_errors = 0;
    int exp_q[$];
    int m_cnt = 0;
    int m_sum = 0;
    bit m_sig = 1'b0;

    sensor_decimator #(.BW_IN(BW_IN), .BW_OUT(BW_OUT), .LOG2_N(LOG2_N)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .data_is_signed (data_is_signed),
        .clr            (clr),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .frame_busy     (frame_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Round-half-up of the frame average via integer arithmetic, wrapped to BW_OUT bits.
    task automatic model_accept(input logic [BW_IN-1:0] d, input logic sig);
        int v;
        if (m_cnt == 0) m_sig = sig;
        v = m_sig ? int'($signed(d)) : int'(d);
        m_sum += v;
        m_cnt++;
        if (m_cnt == N) begin
            exp_q.push_back(((m_sum + 8) >>> 4) & 7);
            m_cnt = 0;
            m_sum = 0;
        end
    endtask

    task automatic model_clear();
        m_cnt = 0;
        m_sum = 0;
    endtask

    task automatic send(input logic [BW_IN-1:0] d, input logic sig);
        int  waited = 0;
        bit  done   = 1'b0;
        @(posedge clk); #2;
        in_valid = 1'b1;
        in_data = d;
        data_is_signed = sig;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                model_accept(d, sig);
                done = 1'b1;
            end else if (++waited > 50) begin
                chk("send_timeout", waited, 0);
                done = 1'b1;
            end
        end
        @(posedge clk); #2;
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("sb_unexpected", exp_q.size(), 1);
            else                   chk("sb_data", out_data, exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_frame_busy", frame_busy, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk) rst_n = 1'b1;

        // Unsigned averaging and half-up rounding
        repeat (N) send(5'd5, 1'b0);
        chk("u5_valid", out_valid, 1);
        chk("u5_data", out_data, 1);
        repeat (N) send(5'd6, 1'b0);
        chk("u6_data", out_data, 2);

        // Signed frames
        repeat (N) send(5'h1F, 1'b1);
        chk("sm1_data", out_data, 0);
        repeat (N) send(5'h18, 1'b1);
        chk("sm8_data", out_data, 6);

        // Unsigned wrap and frame_busy tracking
        for (int i = 0; i < N; i++) begin
            send(5'd31, 1'b0);
            chk("busy_track", frame_busy, (i < N - 1) ? 1 : 0);
        end
        chk("u31_data", out_data, 0);

        // Backpressure: result held, Nth sample of next frame stalls, then pop and accept together
        @(posedge clk); #2 out_ready = 1'b0;
        repeat (N) send(5'd5, 1'b0);
        repeat (N - 1) send(5'd5, 1'b0);
        @(posedge clk); #2;
        in_valid = 1'b1;
        in_data = 5'd5;
        data_is_signed = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, 1);
        end
        @(posedge clk); #2 out_ready = 1'b1;
        @(negedge clk);
        chk("pop_in_ready", in_ready, 1);
        if (in_ready) model_accept(5'd5, 1'b0);
        @(posedge clk); #2 in_valid = 1'b0;
        chk("pop_next_valid", out_valid, 1);
        chk("pop_next_data", out_data, 1);

        // clr discards the partial frame and blocks accept that cycle
        send(5'd7, 1'b0);
        send(5'd7, 1'b0);
        @(posedge clk); #2;
        clr = 1'b1;
        in_valid = 1'b1;
        in_data = 5'd7;
        @(negedge clk);
        chk("clr_in_ready", in_ready, 0);
        model_clear();
        @(posedge clk); #2;
        clr = 1'b0;
        in_valid = 1'b0;
        chk("clr_busy", frame_busy, 0);
        repeat (N) send(5'd5, 1'b0);
        chk("clr_data", out_data, 1);

        // Mode latched on the first sample of a frame
        send(5'h1F, 1'b1);
        repeat (N - 1) send(5'h1F, 1'b0);
        chk("mode_sm1_data", out_data, 0);
        send(5'd5, 1'b0);
        repeat (N - 1) send(5'h1F, 1'b1);
        chk("mode_unsigned_data", out_data, 6);

        // Mixed stream with random backpressure
        for (int i = 0; i < 4 * N; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            send(BW_IN'($urandom), 1'($urandom));
        end
        @(posedge clk); #2 out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2 chk("mixed_drained", exp_q.size(), 0);

        // Asynchronous reset with a pending result and a partial frame
        out_ready = 1'b0;
        repeat (N) send(5'd6, 1'b0);
        send(5'd3, 1'b0);
        send(5'd3, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_busy", frame_busy, 0);
        exp_q.delete();
        model_clear();
        @(negedge clk) rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (N) send(5'd6, 1'b0);
        chk("post_rst_data", out_data, 2);

        repeat (5) @(posedge clk);
        #2 chk("sb_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
